// File: rtl/test_status_monitor_pkg.sv
// Shared types and default register indices for the test status monitor.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package test_status_monitor_pkg;

  // Monitor life cycle: idle, test running, settling after END, then a sticky verdict
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_SETTLE,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } tsm_state_e;

  // Default register-file indices used by the test software
  localparam int DEF_NUM_REG  = 3;
  localparam int DEF_END_REG  = 26;
  localparam int DEF_PASS_REG = 27;

  // Default timing
  localparam int DEF_SETTLE_CYCLES  = 5;
  localparam int DEF_TIMEOUT_CYCLES = 1000;

  // True for the three sticky verdict states
  function automatic logic is_verdict(input tsm_state_e s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/test_status_monitor.sv
// Snoops register-file writes to detect end of a self-checking test and report its verdict.
// Latency: done_o rises SETTLE_CYCLES+1 edges after the edge that samples the END write.
// Backpressure: none; writes are observed passively and never stalled.
module test_status_monitor
  import test_status_monitor_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int END_REG        = DEF_END_REG,
  parameter int PASS_REG       = DEF_PASS_REG,
  parameter int NUM_REG        = DEF_NUM_REG,
  parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             clear_i,
  input  logic             we_i,
  input  logic [4:0]       waddr_i,
  input  logic [XLEN-1:0]  wdata_i,
  output logic             done_o,
  output logic             pass_o,
  output logic             fail_o,
  output logic             timeout_o,
  output logic [XLEN-1:0]  testnum_o,
  output logic [CNT_W-1:0] cycles_o
);

  // Settle counter only needs to hold SETTLE_CYCLES-1
  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  localparam logic [XLEN-1:0]  ONE_VAL    = XLEN'(1);
  localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [SW-1:0]    SETTLE_LD  = SW'(SETTLE_CYCLES - 1);
  localparam logic [4:0]       END_IDX    = 5'(END_REG);
  localparam logic [4:0]       PASS_IDX   = 5'(PASS_REG);
  localparam logic [4:0]       NUM_IDX    = 5'(NUM_REG);

  tsm_state_e       r_state;
  logic [SW-1:0]    r_settle;
  logic [CNT_W-1:0] r_cycles;
  logic [XLEN-1:0]  r_pass_shadow;
  logic [XLEN-1:0]  r_num_shadow;
  logic             r_done;
  logic             r_pass;
  logic             r_fail;
  logic             r_timeout;

  // x0 is hardwired zero in the register file, so index 0 never matches
  logic w_wr_ok;
  logic w_end_trig;
  logic w_pass_wr;
  logic w_num_wr;
  logic w_to_hit;
  logic w_pass_now;

  // Decode snooped writes and the per-cycle transition conditions.
  // END_REG has no output, so only its write strobe matters and no shadow is kept.
  always_comb begin
    w_wr_ok    = we_i && (waddr_i != 5'd0);
    w_end_trig = w_wr_ok && (waddr_i == END_IDX) && (wdata_i == ONE_VAL);
    w_pass_wr  = w_wr_ok && (waddr_i == PASS_IDX);
    w_num_wr   = w_wr_ok && (waddr_i == NUM_IDX);
    w_to_hit   = (TIMEOUT_CYCLES != 0) && (r_cycles == TO_VAL);
    // A PASS_REG write landing on the decision cycle still counts
    w_pass_now = w_pass_wr ? (wdata_i == ONE_VAL) : (r_pass_shadow == ONE_VAL);
  end

  // Monitor FSM with shadows, cycle counter, settle counter and registered status flags
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      r_state       <= ST_IDLE;
      r_settle      <= '0;
      r_cycles      <= '0;
      r_pass_shadow <= '0;
      r_num_shadow  <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      // Flags trail the state by one edge, giving the extra cycle of verdict latency
      r_done    <= is_verdict(r_state);
      r_pass    <= (r_state == ST_PASS);
      r_fail    <= (r_state == ST_FAIL) || (r_state == ST_TIMEOUT);
      r_timeout <= (r_state == ST_TIMEOUT);

      // Shadows follow the register file whenever a test is active or finished
      if (r_state != ST_IDLE) begin
        if (w_pass_wr) r_pass_shadow <= wdata_i;
        if (w_num_wr)  r_num_shadow  <= wdata_i;
      end

      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_state       <= ST_RUN;
            r_cycles      <= '0;
            r_pass_shadow <= '0;
            r_num_shadow  <= '0;
          end
        end
        ST_RUN: begin
          // END beats timeout; cycles_o freezes on the edge that leaves RUN
          if (w_end_trig) begin
            r_state  <= ST_SETTLE;
            r_settle <= SETTLE_LD;
          end else if (w_to_hit) begin
            r_state <= ST_TIMEOUT;
          end else if (r_cycles != '1) begin
            r_cycles <= r_cycles + CNT_W'(1);
          end
        end
        ST_SETTLE: begin
          if (r_settle == '0) begin
            r_state <= w_pass_now ? ST_PASS : ST_FAIL;
          end else begin
            r_settle <= r_settle - SW'(1);
          end
        end
        default: begin
          // Verdict states are sticky until clear or reset
          r_state <= r_state;
        end
      endcase
    end
  end

  assign done_o    = r_done;
  assign pass_o    = r_pass;
  assign fail_o    = r_fail;
  assign timeout_o = r_timeout;
  assign testnum_o = r_num_shadow;
  assign cycles_o  = r_cycles;

endmodule

// File: tb/tb_test_status_monitor.sv
// Self-checking bench for test_status_monitor: directed scenarios plus random traffic.
// Latency: checks every cycle against a timestamp-based reference model.
// Backpressure: n/a.
module tb_test_status_monitor;

  localparam int XLEN  = 32;
  localparam int CNT_W = 32;
  localparam int SETTLE = 5;
  localparam int TMO    = 20;

  logic             clk;
  logic             rst;
  logic             start_i;
  logic             clear_i;
  logic             we_i;
  logic [4:0]       waddr_i;
  logic [XLEN-1:0]  wdata_i;
  logic             done_o;
  logic             pass_o;
  logic             fail_o;
  logic             timeout_o;
  logic [XLEN-1:0]  testnum_o;
  logic [CNT_W-1:0] cycles_o;

  test_status_monitor #(
    .XLEN(XLEN), .END_REG(26), .PASS_REG(27), .NUM_REG(3),
    .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TMO), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i),
    .we_i(we_i), .waddr_i(waddr_i), .wdata_i(wdata_i),
    .done_o(done_o), .pass_o(pass_o), .fail_o(fail_o), .timeout_o(timeout_o),
    .testnum_o(testnum_o), .cycles_o(cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Phase: 0 idle, 1 running, 2 settling, 3 decided. Settling is tracked by the
  // edge number at which END was sampled; the verdict lands SETTLE edges later.
  int          m_phase = 0;
  int          m_verdict = 0;   // 0 pass, 1 fail, 2 timeout
  longint      m_cyc = 0;
  int          m_edge = 0;
  int          m_end_edge = 0;
  logic [31:0] m_pass = '0;
  logic [31:0] m_num = '0;
  logic        e_done = 0, e_pass = 0, e_fail = 0, e_to = 0;
  longint      CYC_MAX = (longint'(1) << CNT_W) - 1;

  always @(posedge clk) begin
    bit wr_ok;
    bit is_end;
    m_edge++;
    if (rst || clear_i) begin
      m_phase = 0; m_cyc = 0; m_pass = '0; m_num = '0;
      e_done = 0; e_pass = 0; e_fail = 0; e_to = 0;
    end else begin
      // Reported flags describe the outcome already decided before this edge
      e_done = (m_phase == 3);
      e_pass = (m_phase == 3) && (m_verdict == 0);
      e_fail = (m_phase == 3) && (m_verdict != 0);
      e_to   = (m_phase == 3) && (m_verdict == 2);
      wr_ok  = we_i && (waddr_i != 0);
      if (m_phase == 0) begin
        if (start_i) begin
          m_phase = 1; m_cyc = 0; m_pass = '0; m_num = '0;
        end
      end else begin
        is_end = (m_phase == 1) && wr_ok && (waddr_i == 26) && (wdata_i == 1);
        if (wr_ok && waddr_i == 27) m_pass = wdata_i;
        if (wr_ok && waddr_i == 3)  m_num  = wdata_i;
        if (m_phase == 1) begin
          if (is_end) begin
            m_phase = 2; m_end_edge = m_edge;
          end else if (TMO != 0 && m_cyc == TMO) begin
            m_phase = 3; m_verdict = 2;
          end else if (m_cyc < CYC_MAX) begin
            m_cyc = m_cyc + 1;
          end
        end else if (m_phase == 2 && m_edge == m_end_edge + SETTLE) begin
          m_phase = 3; m_verdict = (m_pass == 1) ? 0 : 1;
        end
      end
    end
  end

  // Compare process: every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_en) begin
      chk("flags{done,pass,fail,timeout}", {60'd0, done_o, pass_o, fail_o, timeout_o},
          {60'd0, e_done, e_pass, e_fail, e_to});
      chk("testnum_o", {32'd0, testnum_o}, {32'd0, m_num});
      chk("cycles_o", {32'd0, cycles_o}, m_cyc[63:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input logic r, input logic s, input logic c,
                      input logic w, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    rst = r; start_i = s; clear_i = c; we_i = w; waddr_i = a; wdata_i = d;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(0, 0, 0, 0, 5'd0, 32'd0);
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    tick(0, 0, 0, 1, a, d);
  endtask

  task automatic chk_flags(input string nm, input logic [3:0] exp);
    chk(nm, {60'd0, done_o, pass_o, fail_o, timeout_o}, {60'd0, exp});
  endtask

  initial begin
    rst = 1; start_i = 0; clear_i = 0; we_i = 0; waddr_i = '0; wdata_i = '0;
    tick(1, 0, 0, 0, 5'd0, 32'd0);
    tick(1, 1, 1, 1, 5'd3, 32'd9);   // reset wins over start/clear/write
    idle(1);
    chk_flags("reset_flags", 4'b0000);
    chk("reset_testnum", {32'd0, testnum_o}, 64'd0);
    chk("reset_cycles", {32'd0, cycles_o}, 64'd0);
    chk_en = 1'b1;

    // Pass: x27=1 then x26=1 at edge N -> done/pass at N+6, cycles frozen
    tick(0, 1, 0, 0, 5'd0, 32'd0);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    idle(6);
    chk_flags("pass_not_yet_N+5", 4'b0000);
    idle(1);
    chk_flags("pass_at_N+6", 4'b1100);
    chk("pass_cycles", {32'd0, cycles_o}, 64'd1);
    tick(0, 1, 0, 0, 5'd0, 32'd0);   // start ignored in verdict
    idle(3);
    chk_flags("pass_sticky", 4'b1100);
    chk("pass_cycles_frozen", {32'd0, cycles_o}, 64'd1);

    // Fail with test number 7
    tick(0, 0, 1, 0, 5'd0, 32'd0);
    tick(0, 1, 0, 0, 5'd0, 32'd0);
    wr(5'd3, 32'd7);
    wr(5'd27, 32'd0);
    wr(5'd26, 32'd1);
    idle(7);
    chk_flags("fail_flags", 4'b1010);
    chk("fail_testnum", {32'd0, testnum_o}, 64'd7);
    chk("fail_cycles", {32'd0, cycles_o}, 64'd2);

    // PASS_REG written during SETTLE still counts
    tick(0, 0, 1, 0, 5'd0, 32'd0);
    tick(0, 1, 0, 0, 5'd0, 32'd0);
    wr(5'd26, 32'd1);
    idle(1);
    wr(5'd27, 32'd1);
    idle(5);
    chk_flags("settle_pass", 4'b1100);

    // Timeout after 20 cycles
    tick(0, 0, 1, 0, 5'd0, 32'd0);
    tick(0, 1, 0, 0, 5'd0, 32'd0);
    idle(23);
    chk_flags("timeout_flags", 4'b1011);
    chk("timeout_cycles", {32'd0, cycles_o}, 64'd20);

    // END on the expiry cycle wins
    tick(0, 0, 1, 0, 5'd0, 32'd0);
    tick(0, 1, 0, 0, 5'd0, 32'd0);
    idle(20);
    wr(5'd26, 32'd1);
    idle(2);
    chk_flags("end_vs_timeout_settling", 4'b0000);
    idle(5);
    chk_flags("end_vs_timeout_fail", 4'b1010);
    chk("end_vs_timeout_cycles", {32'd0, cycles_o}, 64'd20);

    // x26=2 and x0 writes keep RUN; clear mid-SETTLE returns to idle
    tick(0, 0, 1, 0, 5'd0, 32'd0);
    tick(0, 1, 0, 0, 5'd0, 32'd0);
    wr(5'd26, 32'd2);
    wr(5'd0, 32'd1);
    idle(2);
    chk("still_run_cycles", {32'd0, cycles_o}, 64'd3);
    chk_flags("still_run_flags", 4'b0000);
    wr(5'd3, 32'd5);
    wr(5'd26, 32'd1);
    idle(2);
    tick(0, 1, 1, 0, 5'd0, 32'd0);   // clear beats start
    idle(1);
    chk_flags("clear_flags", 4'b0000);
    chk("clear_testnum", {32'd0, testnum_o}, 64'd0);
    chk("clear_cycles", {32'd0, cycles_o}, 64'd0);

    // Reset in PASS, then restart
    tick(0, 1, 0, 0, 5'd0, 32'd0);
    wr(5'd27, 32'd1);
    wr(5'd26, 32'd1);
    idle(7);
    chk_flags("pre_rst_pass", 4'b1100);
    tick(1, 0, 0, 0, 5'd0, 32'd0);
    idle(1);
    chk_flags("rst_in_pass_flags", 4'b0000);
    chk("rst_in_pass_cycles", {32'd0, cycles_o}, 64'd0);
    tick(0, 1, 0, 0, 5'd0, 32'd0);
    idle(2);
    chk("restart_cycles", {32'd0, cycles_o}, 64'd1);

    // Random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [4:0]  a;
      logic [31:0] d;
      case ($urandom_range(0, 4))
        0: a = 5'd0;
        1: a = 5'd3;
        2: a = 5'd26;
        3: a = 5'd27;
        default: a = 5'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0: d = 32'd0;
        1: d = 32'd1;
        2: d = 32'd2;
        default: d = $urandom;
      endcase
      tick(($urandom_range(0, 299) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 79) == 0), ($urandom_range(0, 2) == 0), a, d);
    end
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
